// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scanner.
package display_pkg;

  typedef enum logic {
    PAGE_AB = 1'b0,
    PAGE_C  = 1'b1
  } page_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low gfedcba codes for 0-9; the unused codes 10-15 decode to blank.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

  // Blank test for one digit of a 4-nibble group, including leading-zero suppression.
  function automatic logic digit_blank(input logic [15:0] grp, input logic [1:0] pos);
    logic       lead;
    logic [3:0] nib;
    lead        = 1'b1;
    digit_blank = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      nib = grp[4*i +: 4];
      if (i == int'(pos)) begin
        digit_blank = (nib > 4'd9) || ((nib == 4'd0) && (i != 0) && lead);
      end else if ((i > int'(pos)) && (nib != 4'd0) && (nib <= 4'd9)) begin
        lead = 1'b0;
      end
    end
  endfunction

endpackage

// File: rtl/display_scan_scheduler_seg7_decoder.sv
// Combinational nibble to active-low 7-segment decoder with a blank override.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      seg_o = SEG_TABLE[nibble_i];
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed 8-digit scanner with per-slot blanking, leading-zero
// suppression and manual or auto-rotating page selection.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int DWELL_FRAMES = 1600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_mode,
  input  logic        auto_en,
  input  logic [15:0] digits_A,
  input  logic [15:0] digits_B,
  input  logic [15:0] digits_C,
  output logic [6:0]  segments,
  output logic [7:0]  anodes,
  output logic        page,
  output logic [2:0]  digit_idx
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  BLANK_LIM  = SLOT_W'(BLANK_CYC);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [2:0]         idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  page_e              page_q, page_d;
  logic               sw_meta_q, sw_sync_q;
  logic [3:0]         nib_q, nib_d;
  logic               blank_q, blank_d;
  logic [6:0]         seg_q, seg_d;
  logic [7:0]         an_q, an_d;

  logic        slot_wrap;
  logic        frame_end;
  logic [15:0] grp_sel;
  logic [3:0]  live_nib;
  logic        live_blank;
  logic [3:0]  cur_nib;
  logic        cur_blank;
  logic [6:0]  dec_seg;

  assign slot_wrap = (slot_q == SLOT_LAST);
  assign frame_end = slot_wrap && (idx_q == 3'd7);

  always_comb begin
    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d  = slot_wrap ? idx_q + 3'd1 : idx_q;
  end

  // Digit source for the current slot.
  always_comb begin
    grp_sel = digits_A;
    if (page_q == PAGE_C) begin
      grp_sel = digits_C;
    end else if (idx_q[2]) begin
      grp_sel = digits_B;
    end
    case (idx_q[1:0])
      2'd0:    live_nib = grp_sel[3:0];
      2'd1:    live_nib = grp_sel[7:4];
      2'd2:    live_nib = grp_sel[11:8];
      default: live_nib = grp_sel[15:12];
    endcase
    live_blank = ((page_q == PAGE_C) && idx_q[2]) || digit_blank(grp_sel, idx_q[1:0]);
  end

  // Slot 0 uses the live selection so the latched copy and the first
  // registered output of the slot agree even when BLANK_CYC is 0.
  always_comb begin
    nib_d     = nib_q;
    blank_d   = blank_q;
    cur_nib   = nib_q;
    cur_blank = blank_q;
    if (slot_q == '0) begin
      nib_d     = live_nib;
      blank_d   = live_blank;
      cur_nib   = live_nib;
      cur_blank = live_blank;
    end
  end

  seg7_decoder u_seg7_decoder (
    .nibble_i (cur_nib),
    .blank_i  (cur_blank),
    .seg_o    (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    an_d  = AN_OFF;
    if ((slot_q >= BLANK_LIM) && !cur_blank) begin
      an_d = ~(8'h01 << idx_q);
    end
  end

  // Page only moves on frame end; auto_en overrides the switch.
  always_comb begin
    page_d  = page_q;
    dwell_d = dwell_q;
    if (!auto_en) begin
      dwell_d = '0;
      if (frame_end) begin
        page_d = page_e'(sw_sync_q);
      end
    end else if (frame_end) begin
      if (dwell_q == DWELL_LAST) begin
        page_d  = (page_q == PAGE_AB) ? PAGE_C : PAGE_AB;
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      idx_q     <= '0;
      dwell_q   <= '0;
      page_q    <= PAGE_AB;
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
      nib_q     <= '0;
      blank_q   <= 1'b1;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else begin
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      page_q    <= page_d;
      sw_meta_q <= sw_mode;
      sw_sync_q <= sw_meta_q;
      nib_q     <= nib_d;
      blank_q   <= blank_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign segments  = seg_q;
  assign anodes    = an_q;
  assign page      = page_q;
  assign digit_idx = idx_q;

endmodule
